// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: FSM state encoding and port indices shared by the arbiter.
package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE  = 2'd1,
        LOCKED = 2'd2
    } state_t;
    localparam int unsigned PORT_CPU = 0;
    localparam int unsigned PORT_MON = 1;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: 2-way round-robin winner from an eligible mask and the last-winner pointer.
module rr_picker (
    input  logic [1:0] i_elig,
    input  logic       i_last,
    output logic       o_valid,
    output logic       o_win
);
    always_comb begin
        o_valid = |i_elig;
        o_win   = &i_elig ? ~i_last : i_elig[1];
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-port synchronous memory.
// Lock/ownership support is built only when MEM_ARBITER_LOCK_EN is defined.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m0_lock,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  m1_lock,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_out,
    output logic                  busy
);
    logic [1:0]            w_req, w_we, w_lock, w_elig;
    logic [ADDR_WIDTH-1:0] w_addr [2];
    logic [DATA_WIDTH-1:0] w_wdata [2];
    logic                  w_valid, w_win, w_lock_hit;
    logic [1:0]            r_gnt, r_rvalid;
    logic                  r_last, r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_data;
    state_t                r_state, w_next;

    assign w_req[PORT_CPU]   = m0_req;
    assign w_req[PORT_MON]   = m1_req;
    assign w_we[PORT_CPU]    = m0_we;
    assign w_we[PORT_MON]    = m1_we;
    assign w_lock[PORT_CPU]  = m0_lock;
    assign w_lock[PORT_MON]  = m1_lock;
    assign w_addr[PORT_CPU]  = m0_addr;
    assign w_addr[PORT_MON]  = m1_addr;
    assign w_wdata[PORT_CPU] = m0_wdata;
    assign w_wdata[PORT_MON] = m1_wdata;

    // A port whose grant is showing this cycle has its request consumed.
    always_comb begin
        w_elig = w_req & ~r_gnt;
`ifdef MEM_ARBITER_LOCK_EN
        if (r_state == LOCKED) w_elig = w_elig & (r_last ? 2'b10 : 2'b01);
`endif
    end

    rr_picker u_picker (
        .i_elig (w_elig),
        .i_last (r_last),
        .o_valid(w_valid),
        .o_win  (w_win)
    );

`ifdef MEM_ARBITER_LOCK_EN
    assign w_lock_hit = w_valid & w_lock[w_win];
    assign busy       = r_state == LOCKED;
`else
    logic w_unused_lock;
    assign w_unused_lock = ^w_lock;
    assign w_lock_hit    = 1'b0;
    assign busy          = 1'b0;
`endif

    always_comb begin
        w_next = IDLE;
        w_next = w_valid ? (w_lock_hit ? LOCKED : SERVE) : (r_state == LOCKED ? LOCKED : IDLE);
    end

    // In LOCKED only the owner is granted, so the owner is always the last winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_rvalid   <= '0;
            r_last     <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_state  <= w_next;
            r_gnt    <= {w_valid & w_win, w_valid & ~w_win};
            r_rvalid <= r_gnt & {2{~r_mem_we}};
            r_mem_we <= w_valid & w_we[w_win];
            if (w_valid) begin
                r_last     <= w_win;
                r_mem_addr <= w_addr[w_win];
                r_mem_data <= w_wdata[w_win];
            end
        end
    end

    assign m0_gnt    = r_gnt[PORT_CPU];
    assign m1_gnt    = r_gnt[PORT_MON];
    assign m0_rvalid = r_rvalid[PORT_CPU];
    assign m1_rvalid = r_rvalid[PORT_MON];
    assign m0_rdata  = r_rvalid[PORT_CPU] ? mem_out : '0;
    assign m1_rdata  = r_rvalid[PORT_MON] ? mem_out : '0;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_data  = r_mem_data;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, memory word width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports mN_req  input  1  access request, port N in {0,1}; 0 = CPU, 1 = monitor/loader.
REQ-006 SHALL have ports mN_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports mN_addr  input  ADDR_WIDTH  access address.
REQ-008 SHALL have ports mN_wdata  input  DATA_WIDTH  write data.
REQ-009 SHALL have ports mN_lock  input  1  hold ownership after this access.
REQ-010 SHALL have ports mN_gnt  output  1  one-cycle grant pulse; the access is issued this cycle.
REQ-011 SHALL have ports mN_rvalid  output  1  read data valid pulse.
REQ-012 SHALL have ports mN_rdata  output  DATA_WIDTH  read data; valid only while mN_rvalid = 1.
REQ-013 SHALL have ports mem_we / mem_addr / mem_data  output  1 / ADDR_WIDTH / DATA_WIDTH  to single-port synchronous memory.
REQ-014 SHALL have port mem_out  input  DATA_WIDTH  memory read data, valid one cycle after the access.
REQ-015 SHALL have port busy  output  1  high while in LOCKED state.

Function
REQ-016 SHALL sample requests at cycle T and assert at most one mN_gnt in cycle T+1, with mem_we/mem_addr/mem_data registered from the winner in the same cycle.
REQ-017 SHALL drive mem_we = 0 in every cycle without a grant; mem_addr/mem_data SHALL hold their last values.
REQ-018 SHALL require a requester to hold req/we/addr/wdata/lock stable until its gnt; a request dropped before gnt is abandoned without error.
REQ-019 SHALL ignore mN_req in a cycle where mN_gnt = 1 (consumed request); a lone port therefore achieves one access per 2 cycles, alternating ports one per cycle.
REQ-020 SHALL arbitrate round-robin when both ports are eligible: the port not granted last wins; last-winner pointer resets to 1, so port 0 wins the first contention.
REQ-021 SHALL, for a granted read at T+1, assert mN_rvalid at T+2 with mN_rdata = mem_out; writes produce no rvalid.
REQ-022 SHALL implement FSM IDLE -> SERVE (grant issued) -> IDLE/SERVE (next request present) and SERVE -> LOCKED (granted access had lock = 1).
REQ-023 SHALL in LOCKED grant only the owning port; the other port waits, its request retained.
REQ-024 SHALL leave LOCKED to SERVE/IDLE after an owner access granted with lock = 0; owner dropping req alone SHALL NOT release the lock.
REQ-025 SHALL treat simultaneous write by one port and pending rvalid of the other as independent; rvalid routing uses the registered grant, not current requests.

Reset
REQ-026 SHALL on rst: FSM to IDLE, all mN_gnt, mN_rvalid, mem_we, busy = 0, mem_addr/mem_data/mN_rdata = 0, last-winner = 1.
REQ-027 SHALL discard an in-flight read when rst is asserted mid-operation (no rvalid after reset).

Configuration
REQ-028 SHALL compile lock support only under macro MEM_ARBITER_LOCK_EN; without it mN_lock ports remain but are ignored, LOCKED state is absent and busy is tied 0.

Structure
REQ-029 SHALL place the FSM state encoding (IDLE, SERVE, LOCKED) and port index constants in shared package mem_arbiter_pkg.
REQ-030 SHALL use one sub-module rr_picker (2-way round-robin winner from eligible mask and last-winner pointer).

Verification
REQ-031 SHALL cover: m0 read addr 5, mem[5] = 16'h1234 -> m0_gnt at T+1, m0_rvalid with 16'h1234 at T+2, m1 signals idle.
REQ-032 SHALL cover: both ports request continuously after reset -> grants alternate 0,1,0,1; mem_we = 0 on read cycles.
REQ-033 SHALL cover: m1 write addr 10 data 16'hBEEF with lock = 1, m0 requesting -> busy = 1, m0 blocked until m1 access with lock = 0, then m0 granted next cycle.
REQ-034 SHALL cover: rst asserted in cycle of m0 read grant -> no m0_rvalid, all outputs 0 next cycle.
REQ-035 SHALL cover: lone m0 holding req high -> m0_gnt every second cycle, never two consecutive.
